// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect input, PC exports, imem req/ack and decode valid/ready.
// fetch_count exists only when FETCH_PERF_CNT_EN is defined.
interface pc_fetch_unit_if;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] inst;
   logic        inst_valid;
   logic        inst_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
`endif

   modport master (
      input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
      output pc, pc_plus2, imem_req, imem_addr, inst, inst_valid
`ifdef FETCH_PERF_CNT_EN
      , output fetch_count
`endif
   );

   modport slave (
      output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
      input  pc, pc_plus2, imem_req, imem_addr, inst, inst_valid
`ifdef FETCH_PERF_CNT_EN
      , input fetch_count
`endif
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register + one-at-a-time fetch sequencer (IDLE/REQ/HOLD); redirect wins over ack/ready.
// Fetch latency >= 1 cycle, issue every >= 2 cycles; HOLD stalls on inst_ready. Optional counter: FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic            clk,
   input  logic            reset,
   pc_fetch_unit_if.master bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [15:0] PC_INIT = RESET_PC & 16'hFFFE;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pc;
   logic [15:0] w_pc_nxt;
   logic [15:0] w_pc_plus2;
   logic [15:0] r_inst;
   logic [15:0] w_inst_nxt;
   logic        r_inst_valid;
   logic        w_inst_valid_nxt;
   logic        r_imem_req;
   logic        w_imem_req_nxt;

   assign w_pc_plus2 = r_pc + 16'd2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= PC_INIT;
         r_inst       <= 16'h0000;
         r_inst_valid <= 1'b0;
         r_imem_req   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_inst       <= w_inst_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_imem_req   <= w_imem_req_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_inst_nxt       = r_inst;
      w_inst_valid_nxt = r_inst_valid;
      // Redirect discards any same-cycle ack data or decode acceptance.
      if (bus.redirect) begin
         w_pc_nxt         = {bus.redirect_pc[15:1], 1'b0};
         w_inst_valid_nxt = 1'b0;
         w_state_nxt      = ST_REQ;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
               if (bus.imem_ack) begin
                  w_inst_nxt       = bus.imem_rdata;
                  w_inst_valid_nxt = 1'b1;
                  w_pc_nxt         = w_pc_plus2;
                  w_state_nxt      = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.inst_ready) begin
                  w_inst_valid_nxt = 1'b0;
                  w_state_nxt      = ST_REQ;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
      w_imem_req_nxt = (w_state_nxt == ST_REQ);
   end

   assign bus.pc         = r_pc;
   assign bus.pc_plus2   = w_pc_plus2;
   assign bus.imem_req   = r_imem_req;
   assign bus.imem_addr  = r_pc;
   assign bus.inst       = r_inst;
   assign bus.inst_valid = r_inst_valid;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_fetch_count;
   logic        w_accept;

   assign w_accept = r_inst_valid && bus.inst_ready && !bus.redirect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_count <= 16'h0000;
      end else if (w_accept) begin
         r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   assign bus.fetch_count = r_fetch_count;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic against a transaction model.
module tb_pc_fetch_unit;
   localparam logic [15:0] RST_PC = 16'h0011;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   pc_fetch_unit_if bus();

   pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: started = left reset, fetching = request outstanding, valid = word held for decode.
   logic        m_started;
   logic        m_fetching;
   logic        m_valid;
   logic [15:0] m_pc;
   logic [15:0] m_inst;
   logic [15:0] m_cnt;

   task automatic clear_inputs();
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 16'h0000;
      bus.inst_ready  = 1'b0;
   endtask

   task automatic model_reset();
      m_started  = 1'b0;
      m_fetching = 1'b0;
      m_valid    = 1'b0;
      m_pc       = RST_PC & 16'hFFFE;
      m_inst     = 16'h0000;
      m_cnt      = 16'h0000;
   endtask

   task automatic tick();
      logic        f;
      logic        v;
      logic [15:0] p;
      logic [15:0] i;
      logic [15:0] c;
      f = m_fetching; v = m_valid; p = m_pc; i = m_inst; c = m_cnt;
      if (bus.redirect) begin
         p = bus.redirect_pc & 16'hFFFE; v = 1'b0; f = 1'b1;
      end else if (!m_started) begin
         f = 1'b1;
      end else if (m_fetching && bus.imem_ack) begin
         i = bus.imem_rdata; v = 1'b1; p = m_pc + 16'd2; f = 1'b0;
      end else if (m_valid && bus.inst_ready) begin
         v = 1'b0; f = 1'b1; c = m_cnt + 16'd1;
      end
      @(posedge clk);
      #1;
      m_started = 1'b1; m_fetching = f; m_valid = v; m_pc = p; m_inst = i; m_cnt = c;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.pc !== 16'h0010) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 16'h0010); end
      checks++; if (bus.pc_plus2 !== 16'h0012) begin failures++; $display("FAIL reset_pc_plus2 got=%h exp=%h", bus.pc_plus2, 16'h0012); end
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
      checks++; if (bus.inst !== 16'h0000) begin failures++; $display("FAIL reset_inst got=%h exp=0000", bus.inst); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (bus.fetch_count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", bus.fetch_count); end
`endif
      reset = 1'b1;
      tick();
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 16'h0010) begin failures++; $display("FAIL first_addr got=%h exp=%h", bus.imem_addr, 16'h0010); end
   endtask

   task automatic test_first_fetch();
      logic [15:0] d;
      d = 16'($urandom);
      bus.imem_ack = 1'b1; bus.imem_rdata = d;
      tick();
      bus.imem_ack = 1'b0;
      checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL ff_valid got=%b exp=1", bus.inst_valid); end
      checks++; if (bus.inst !== d) begin failures++; $display("FAIL ff_inst got=%h exp=%h", bus.inst, d); end
      checks++; if (bus.pc !== 16'h0012) begin failures++; $display("FAIL ff_pc got=%h exp=0012", bus.pc); end
      checks++; if (bus.pc_plus2 !== 16'h0014) begin failures++; $display("FAIL ff_pc_plus2 got=%h exp=0014", bus.pc_plus2); end
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL ff_req got=%b exp=0", bus.imem_req); end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL ff_accept_valid got=%b exp=0", bus.inst_valid); end
      checks++; if (bus.imem_addr !== 16'h0012 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL ff_next_req got=%b/%h exp=1/0012", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_wait_hold();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL wait_req cyc=%0d got=%b/%b exp=1/0", k, bus.imem_req, bus.inst_valid); end
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 16'hABCD;
      tick();
      bus.imem_ack = 1'b0; bus.imem_rdata = 16'h5555;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.inst !== 16'hABCD || bus.inst_valid !== 1'b1) begin failures++; $display("FAIL hold_inst cyc=%0d got=%h/%b exp=abcd/1", k, bus.inst, bus.inst_valid); end
         checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL hold_req cyc=%0d got=%b exp=0", k, bus.imem_req); end
         bus.imem_ack = k[0];
         tick();
      end
      bus.imem_ack = 1'b0;
   endtask

   task automatic test_redirect_hold();
      logic [15:0] cnt_before;
      cnt_before = m_cnt;
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0201; bus.inst_ready = 1'b1;
      tick();
      bus.redirect = 1'b0; bus.inst_ready = 1'b0;
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rdh_valid got=%b exp=0", bus.inst_valid); end
      checks++; if (bus.pc !== 16'h0200) begin failures++; $display("FAIL rdh_pc got=%h exp=0200", bus.pc); end
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rdh_req got=%b exp=1", bus.imem_req); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (bus.fetch_count !== cnt_before) begin failures++; $display("FAIL rdh_count got=%h exp=%h", bus.fetch_count, cnt_before); end
`else
      if (cnt_before === 16'hxxxx) $display("note: model count unknown");
`endif
   endtask

   task automatic test_redirect_ack();
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0400; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
      tick();
      bus.redirect = 1'b0; bus.imem_ack = 1'b0;
      checks++; if (bus.pc !== 16'h0400) begin failures++; $display("FAIL rda_pc got=%h exp=0400", bus.pc); end
      checks++; if (bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rda_state got=%b/%b exp=1/0", bus.imem_req, bus.inst_valid); end
      checks++; if (bus.inst !== 16'hABCD) begin failures++; $display("FAIL rda_dropped got=%h exp=abcd", bus.inst); end
   endtask

   task automatic test_wrap();
      bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
      tick();
      bus.redirect = 1'b0;
      checks++; if (bus.pc !== 16'hFFFE || bus.pc_plus2 !== 16'h0000) begin failures++; $display("FAIL wrap_pre got=%h/%h exp=fffe/0000", bus.pc, bus.pc_plus2); end
      bus.imem_ack = 1'b1; bus.imem_rdata = 16'h7E57;
      tick();
      bus.imem_ack = 1'b0;
      checks++; if (bus.pc !== 16'h0000 || bus.pc_plus2 !== 16'h0002) begin failures++; $display("FAIL wrap_post got=%h/%h exp=0000/0002", bus.pc, bus.pc_plus2); end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_req got=%b/%h exp=1/0000", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bus.redirect    = ($urandom_range(7) == 0);
         bus.redirect_pc = 16'($urandom);
         bus.imem_ack    = $urandom_range(1);
         bus.imem_rdata  = 16'($urandom);
         bus.inst_ready  = $urandom_range(1);
         tick();
         checks++;
         if (bus.pc !== m_pc || bus.pc_plus2 !== m_pc + 16'd2 || bus.imem_addr !== m_pc ||
             bus.imem_req !== m_fetching || bus.inst_valid !== m_valid || bus.inst !== m_inst) begin
            failures++;
            $display("FAIL rand cyc=%0d got pc=%h p2=%h addr=%h req=%b vld=%b inst=%h exp pc=%h req=%b vld=%b inst=%h",
                     n, bus.pc, bus.pc_plus2, bus.imem_addr, bus.imem_req, bus.inst_valid, bus.inst,
                     m_pc, m_fetching, m_valid, m_inst);
         end
`ifdef FETCH_PERF_CNT_EN
         checks++; if (bus.fetch_count !== m_cnt) begin failures++; $display("FAIL rand_count cyc=%0d got=%h exp=%h", n, bus.fetch_count, m_cnt); end
`endif
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         bus.imem_ack = 1'b1; bus.imem_rdata = 16'($urandom);
         tick();
         bus.imem_ack = 1'b0; bus.inst_ready = 1'b1;
         tick();
         bus.inst_ready = 1'b0;
      end
      checks++; if (bus.imem_req !== 1'b1 || bus.pc !== 16'h001A) begin failures++; $display("FAIL mid_pre got=%b/%h exp=1/001a", bus.imem_req, bus.pc); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (bus.fetch_count !== 16'd5) begin failures++; $display("FAIL mid_count got=%0d exp=5", bus.fetch_count); end
`endif
      bus.imem_ack = 1'b1;
      reset = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%b exp=0/0", bus.imem_req, bus.inst_valid); end
      checks++; if (bus.pc !== 16'h0010) begin failures++; $display("FAIL mid_pc got=%h exp=0010", bus.pc); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (bus.fetch_count !== 16'd0) begin failures++; $display("FAIL mid_count_clr got=%0d exp=0", bus.fetch_count); end
`endif
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_wait_hold();
      test_redirect_hold();
      test_redirect_ack();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
